// File: rtl/led_panel_pkg.sv
// led_panel_pkg: shared geometry defaults and pixel type for the LED panel driver and sink.
//   DEF_COLS / DEF_ROWS : default panel geometry
//   DEF_COL_W / DEF_ROW_W : index widths derived from the geometry
//   rgb_t : one {r,g,b} pixel
package led_panel_pkg;

    localparam int DEF_COLS  = 32;
    localparam int DEF_ROWS  = 8;
    localparam int DEF_COL_W = $clog2(DEF_COLS);
    localparam int DEF_ROW_W = $clog2(DEF_ROWS);

    typedef logic [2:0] rgb_t;

endpackage

// File: rtl/led_panel_sync_edge.sv
// led_panel_sync_edge: two-flop synchronizer with a history flop for rising-edge detection.
//   clk, reset : system clock, asynchronous active-low reset
//   d_in       : asynchronous panel pin
//   sync_o     : synchronized level
//   rise_o     : one-cycle high when the synchronized level goes 0 -> 1
module led_panel_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic sync_o,
    output logic rise_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;
    logic hist_d, hist_q;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/led_panel_sink.sv
// led_panel_sink: receiving end of a HUB-style LED panel; rebuilds the displayed frame in a readable store.
//   clk, reset                      : system clock, asynchronous active-low reset
//   red/green/blue_in, sclk_in      : serial pixel data, shifted on sclk rising edge
//   latch_in, aclk_in, arst_in      : row transfer, row advance, row address reset (level)
//   blank_in                        : display off when high
//   rd_row, rd_col -> rd_rgb        : registered pixel readback
//   row_addr, row_lit               : decoded row address and lit status
//   frame_pulse, frame_count        : row wrap indication and wrap count
//   err_overflow, err_short         : sticky shift-count errors
module led_panel_sink
    import led_panel_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red_in,
    input  logic             green_in,
    input  logic             blue_in,
    input  logic             sclk_in,
    input  logic             latch_in,
    input  logic             aclk_in,
    input  logic             arst_in,
    input  logic             blank_in,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [2:0]       rd_rgb,
    output logic [ROW_W-1:0] row_addr,
    output logic             row_lit,
    output logic             frame_pulse,
    output logic [15:0]      frame_count,
    output logic             err_overflow,
    output logic             err_short
);

    localparam int CNT_W = $clog2(COLS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    // Pin order: 0 red, 1 green, 2 blue, 3 sclk, 4 latch, 5 aclk, 6 arst, 7 blank
    logic [7:0] pins, sync, rise;

    assign pins = {blank_in, arst_in, aclk_in, latch_in, sclk_in, blue_in, green_in, red_in};

    for (genvar g = 0; g < 8; g++) begin : g_sync
        led_panel_sync_edge u_sync (
            .clk    (clk),
            .reset  (reset),
            .d_in   (pins[g]),
            .sync_o (sync[g]),
            .rise_o (rise[g])
        );
    end

    // Edges on data/arst/blank pins and levels on strobe pins carry no meaning.
    logic unused;
    assign unused = ^{rise[2:0], rise[7:6], sync[5:3]};

    rgb_t rgb_s;
    logic sclk_e, latch_e, aclk_e, arst_s, blank_s;

    assign rgb_s   = {sync[0], sync[1], sync[2]};
    assign sclk_e  = rise[3];
    assign latch_e = rise[4];
    assign aclk_e  = rise[5];
    assign arst_s  = sync[6];
    assign blank_s = sync[7];

    rgb_t [COLS-1:0]            sr_d, sr_q;
    rgb_t [ROWS-1:0][COLS-1:0]  store_d, store_q;
    logic [CNT_W-1:0]           cnt_d, cnt_q, cnt_sh;
    logic [ROW_W-1:0]           row_d, row_q;
    logic                       wrap;
    logic                       fp_d, fp_q;
    logic [15:0]                fc_d, fc_q;
    logic                       ovf_d, ovf_q;
    logic                       short_d, short_q;
    logic                       lit_d, lit_q;
    rgb_t                       rd_d, rd_q;

    // Shift is applied before latch so a coincident latch stores the post-shift row
    // and judges completeness on the post-shift count; latch writes the pre-increment row.
    always_comb begin
        sr_d    = sclk_e ? {sr_q[COLS-2:0], rgb_s} : sr_q;
        cnt_sh  = (sclk_e && cnt_q != CNT_FULL) ? cnt_q + 1'b1 : cnt_q;
        cnt_d   = latch_e ? '0 : cnt_sh;
        ovf_d   = ovf_q | (sclk_e && cnt_q == CNT_FULL);
        short_d = short_q | (latch_e && cnt_sh != CNT_FULL);
        store_d = store_q;
        store_d[row_q] = latch_e ? sr_d : store_q[row_q];
        wrap    = aclk_e && row_q == ROW_LAST;
        row_d   = (arst_s || wrap) ? '0 : aclk_e ? row_q + 1'b1 : row_q;
        fp_d    = wrap && !arst_s;
        fc_d    = fc_q + 16'(fp_d);
        lit_d   = ~blank_s;
        rd_d    = (int'(rd_row) < ROWS && int'(rd_col) < COLS) ? store_q[rd_row][rd_col] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            store_q <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            fp_q    <= 1'b0;
            fc_q    <= '0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
            lit_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            sr_q    <= sr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            fp_q    <= fp_d;
            fc_q    <= fc_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
            lit_q   <= lit_d;
            rd_q    <= rd_d;
        end
    end

    assign rd_rgb       = rd_q;
    assign row_addr     = row_q;
    assign row_lit      = lit_q;
    assign frame_pulse  = fp_q;
    assign frame_count  = fc_q;
    assign err_overflow = ovf_q;
    assign err_short    = short_q;

endmodule

// File: tb/tb_led_panel_sink.sv
// tb_led_panel_sink: randomized bench for led_panel_sink against a frame-level reference model.
module tb_led_panel_sink;

    localparam int COLS = 32;
    localparam int ROWS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
    logic        sclk_in = 1'b0, latch_in = 1'b0, aclk_in = 1'b0, arst_in = 1'b0, blank_in = 1'b0;
    logic [2:0]  rd_row = '0;
    logic [4:0]  rd_col = '0;
    logic [2:0]  rd_rgb;
    logic [2:0]  row_addr;
    logic        row_lit, frame_pulse, err_overflow, err_short;
    logic [15:0] frame_count;

    led_panel_sink dut (
        .clk          (clk),
        .reset        (reset),
        .red_in       (red_in),
        .green_in     (green_in),
        .blue_in      (blue_in),
        .sclk_in      (sclk_in),
        .latch_in     (latch_in),
        .aclk_in      (aclk_in),
        .arst_in      (arst_in),
        .blank_in     (blank_in),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_rgb       (rd_rgb),
        .row_addr     (row_addr),
        .row_lit      (row_lit),
        .frame_pulse  (frame_pulse),
        .frame_count  (frame_count),
        .err_overflow (err_overflow),
        .err_short    (err_short)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int fp_seen = 0;

    always @(negedge clk) if (frame_pulse === 1'b1) fp_seen++;

    // Reference model: what the panel should be showing
    logic [2:0] m_sr    [COLS];
    logic [2:0] m_store [ROWS][COLS];
    int m_cnt, m_row, m_frames, m_pulses;
    bit m_ovf, m_short;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_clear();
        foreach (m_sr[c]) m_sr[c] = '0;
        foreach (m_store[r, c]) m_store[r][c] = '0;
        m_cnt = 0;
        m_row = 0;
        m_frames = 0;
        m_ovf = 0;
        m_short = 0;
    endtask

    // Drive one strobe event (any combination of pins rising together) and update the model.
    task automatic strobe(input bit s, input bit l, input bit a, input bit r, input logic [2:0] px);
        {red_in, green_in, blue_in} = px;
        sclk_in = s; latch_in = l; aclk_in = a; arst_in = r;
        hold(4);
        sclk_in = 0; latch_in = 0; aclk_in = 0; arst_in = 0;
        hold(4);
        if (s) begin
            for (int c = COLS - 1; c > 0; c--) m_sr[c] = m_sr[c-1];
            m_sr[0] = px;
            if (m_cnt == COLS) m_ovf = 1; else m_cnt++;
        end
        if (l) begin
            for (int c = 0; c < COLS; c++) m_store[m_row][c] = m_sr[c];
            if (m_cnt != COLS) m_short = 1;
            m_cnt = 0;
        end
        if (r) m_row = 0;
        else if (a) begin
            if (m_row == ROWS - 1) begin
                m_frames++;
                m_pulses++;
            end
            m_row = (m_row + 1) % ROWS;
        end
    endtask

    task automatic shifts(input int n, input int mode);
        for (int i = 0; i < n; i++)
            strobe(1, 0, 0, 0, mode == 0 ? 3'($urandom_range(0, 7)) : mode == 1 ? ((i % 2) ? 3'b001 : 3'b100) : 3'b010);
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_row = 3'(r);
                rd_col = 5'(c);
                @(negedge clk);
                chk($sformatf("%s pix r%0d c%0d", tag, r, c), 32'(rd_rgb), 32'(m_store[r][c]));
            end
    endtask

    task automatic status(input string tag);
        chk({tag, " row_addr"}, 32'(row_addr), 32'(m_row));
        chk({tag, " frame_count"}, 32'(frame_count), 32'(m_frames[15:0]));
        chk({tag, " frame_pulses"}, 32'(fp_seen), 32'(m_pulses));
        chk({tag, " err_overflow"}, 32'(err_overflow), 32'(m_ovf));
        chk({tag, " err_short"}, 32'(err_short), 32'(m_short));
    endtask

    initial begin
        m_clear();
        m_pulses = 0;
        hold(3);
        chk("rst rd_rgb", 32'(rd_rgb), 0);
        chk("rst row_lit", 32'(row_lit), 0);
        chk("rst frame_pulse", 32'(frame_pulse), 0);
        status("rst");
        reset = 1'b1;
        hold(4);
        chk("lit after reset", 32'(row_lit), 1);

        // Alternating red/blue row into row 0
        shifts(COLS, 1);
        strobe(0, 1, 0, 0, 3'b000);
        status("alt");
        sweep("alt");

        // arst, three row advances, all-green row; last shift coincides with latch
        strobe(0, 0, 0, 1, 3'b000);
        for (int i = 0; i < 3; i++) strobe(0, 0, 1, 0, 3'b000);
        shifts(COLS - 1, 2);
        strobe(1, 1, 0, 0, 3'b010);
        status("green");
        sweep("green");

        // Two full frames of row advances
        strobe(0, 0, 0, 1, 3'b000);
        for (int i = 0; i < ROWS; i++) strobe(0, 0, 1, 0, 3'b000);
        status("frame1");
        for (int i = 0; i < ROWS; i++) strobe(0, 0, 1, 0, 3'b000);
        status("frame2");

        // aclk and arst together at the last row: no wrap pulse
        for (int i = 0; i < ROWS - 1; i++) strobe(0, 0, 1, 0, 3'b000);
        chk("row at last", 32'(row_addr), ROWS - 1);
        strobe(0, 0, 1, 1, 3'b000);
        status("aclk+arst");

        // latch together with aclk: writes the old row
        strobe(0, 0, 1, 0, 3'b000);
        shifts(COLS, 0);
        strobe(0, 1, 1, 0, 3'b000);
        status("latch+aclk");

        // Blanking
        blank_in = 1'b1;
        hold(4);
        chk("blank row_lit", 32'(row_lit), 0);
        blank_in = 1'b0;
        hold(4);
        chk("unblank row_lit", 32'(row_lit), 1);

        // Overflow then short burst
        shifts(COLS + 1, 0);
        strobe(0, 1, 0, 0, 3'b000);
        status("overflow");
        shifts(COLS - 1, 0);
        strobe(0, 1, 0, 0, 3'b000);
        status("short");
        sweep("errs");

        // Random rows and row moves
        for (int k = 0; k < 6; k++) begin
            for (int j = $urandom_range(0, 9); j > 0; j--) strobe(0, 0, 1, 0, 3'b000);
            shifts(COLS, 0);
            strobe(0, 1, $urandom_range(0, 1) == 1, 0, 3'b000);
        end
        status("random");
        sweep("random");

        // Reset mid-burst, then a clean row
        shifts(15, 0);
        reset = 1'b0;
        hold(3);
        m_clear();
        chk("midrst row_addr", 32'(row_addr), 0);
        chk("midrst frame_count", 32'(frame_count), 0);
        reset = 1'b1;
        hold(2);
        shifts(COLS, 0);
        strobe(0, 1, 0, 0, 3'b000);
        status("after rst");
        sweep("after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
